// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: Diff = A - B, one bit per clock, LSB first.
// Optional signed-overflow output is enabled by defining SUB_OVERFLOW_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             Ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Full-subtractor cell: returns {borrow_out, difference}.
  function automatic logic [1:0] fsub(input logic a, input logic b, input logic br);
    fsub = {((~a & b) | (~(a ^ b) & br)), (a ^ b ^ br)};
  endfunction

  // Signed overflow: operand signs differ and the result sign differs from A.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
    sub_ovf = (a_msb ^ b_msb) & (d_msb ^ a_msb);
  endfunction

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] w_res_next;
  logic [WIDTH-1:0] r_diff;
  logic [CW-1:0]    r_count;
  logic             r_borrow;
  logic             r_bout;
  logic             r_busy;
  logic             r_done;
  logic [1:0]       w_cell;
  logic             w_accept;
  logic             w_last;
  logic             w_ovf_next;
`ifdef SUB_OVERFLOW_EN
  logic             r_ovf;
`endif

  // Current bit through the cell and the result with that bit written in.
  always_comb begin
    w_cell     = fsub(r_a[r_count], r_b[r_count], r_borrow);
    w_res_next = r_res;
    w_res_next[r_count] = w_cell[0];
    w_accept   = Start && (r_state != SHIFT);
    w_last     = (r_state == SHIFT) && (r_count == LAST);
    w_ovf_next = sub_ovf(r_a[WIDTH-1], r_b[WIDTH-1], w_cell[0]);
  end

  // Next-state logic; Start only counts in IDLE or DONE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (Start) w_state_next = SHIFT;
        else       w_state_next = IDLE;
      end
      SHIFT: begin
        if (w_last) w_state_next = DONE;
        else        w_state_next = SHIFT;
      end
      DONE: begin
        if (Start) w_state_next = SHIFT;
        else       w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State register with registered Busy/Done decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next == SHIFT);
      r_done  <= (w_state_next == DONE);
    end
  end

  // Operand latch, serial datapath and result registers (results load only on the last bit).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_count  <= '0;
      r_borrow <= 1'b0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      r_ovf    <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a      <= A;
      r_b      <= B;
      r_res    <= '0;
      r_count  <= '0;
      r_borrow <= 1'b0;
    end else if (r_state == SHIFT) begin
      r_res    <= w_res_next;
      r_borrow <= w_cell[1];
      r_count  <= r_count + CW'(1);
      if (w_last) begin
        r_diff <= w_res_next;
        r_bout <= w_cell[1];
`ifdef SUB_OVERFLOW_EN
        r_ovf  <= w_ovf_next;
`endif
      end
    end
  end

  assign Busy = r_busy;
  assign Done = r_done;
  assign Diff = r_diff;
  assign Bout = r_bout;
`ifdef SUB_OVERFLOW_EN
  assign Ovf  = r_ovf;
`else
  logic w_unused;
  assign w_unused = w_ovf_next;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=1 instances).
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] i_a;
  logic [7:0] i_b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bout;
`ifdef SUB_OVERFLOW_EN
  logic       ovf;
  logic       ovf1;
`endif
  logic       s1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       busy1;
  logic       done1;
  logic [0:0] diff1;
  logic       bout1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .Start(start), .A(i_a), .B(i_b),
    .Busy(busy), .Done(done), .Diff(diff), .Bout(bout)
`ifdef SUB_OVERFLOW_EN
    , .Ovf(ovf)
`endif
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .Start(s1), .A(a1), .B(b1),
    .Busy(busy1), .Done(done1), .Diff(diff1), .Bout(bout1)
`ifdef SUB_OVERFLOW_EN
    , .Ovf(ovf1)
`endif
  );

  // Pulse Start for one cycle, scramble operands during SHIFT, wait (bounded) for Done.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, output int lat, output int busy_n);
    @(negedge clk);
    start = 1'b1; i_a = a; i_b = b;
    @(negedge clk);
    start = 1'b0; i_a = 8'hA5; i_b = 8'h3C;
    lat = 1; busy_n = 0;
    while (!done && lat < 40) begin
      if (busy) busy_n++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++; if (diff !== 8'h00)   begin errors++; $display("FAIL reset_diff got=%h exp=00", diff); end
    checks++; if (bout !== 1'b0)    begin errors++; $display("FAIL reset_bout got=%0b exp=0", bout); end
`ifdef SUB_OVERFLOW_EN
    checks++; if (ovf !== 1'b0)     begin errors++; $display("FAIL reset_ovf got=%0b exp=0", ovf); end
`endif
  endtask

  task automatic test_basic();
    int lat, bn;
    run_op(8'd5, 8'd3, lat, bn);
    checks++; if (lat !== 9)        begin errors++; $display("FAIL basic_latency got=%0d exp=9", lat); end
    checks++; if (bn !== 8)         begin errors++; $display("FAIL basic_busy_cycles got=%0d exp=8", bn); end
    checks++; if (diff !== 8'h02)   begin errors++; $display("FAIL basic_5m3_diff got=%h exp=02", diff); end
    checks++; if (bout !== 1'b0)    begin errors++; $display("FAIL basic_5m3_bout got=%0b exp=0", bout); end
`ifdef SUB_OVERFLOW_EN
    checks++; if (ovf !== 1'b0)     begin errors++; $display("FAIL basic_5m3_ovf got=%0b exp=0", ovf); end
`endif
    @(negedge clk);
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL done_one_cycle got=%0b exp=0", done); end
    checks++; if (diff !== 8'h02)   begin errors++; $display("FAIL diff_hold got=%h exp=02", diff); end
    run_op(8'd3, 8'd5, lat, bn);
    checks++; if (diff !== 8'hFE)   begin errors++; $display("FAIL basic_3m5_diff got=%h exp=fe", diff); end
    checks++; if (bout !== 1'b1)    begin errors++; $display("FAIL basic_3m5_bout got=%0b exp=1", bout); end
`ifdef SUB_OVERFLOW_EN
    checks++; if (ovf !== 1'b0)     begin errors++; $display("FAIL basic_3m5_ovf got=%0b exp=0", ovf); end
`endif
    run_op(8'd0, 8'd0, lat, bn);
    checks++; if (diff !== 8'h00)   begin errors++; $display("FAIL basic_0m0_diff got=%h exp=00", diff); end
    checks++; if (bout !== 1'b0)    begin errors++; $display("FAIL basic_0m0_bout got=%0b exp=0", bout); end
  endtask

  task automatic test_overflow();
    int lat, bn;
    run_op(8'h80, 8'h01, lat, bn);
    checks++; if (diff !== 8'h7F)   begin errors++; $display("FAIL ovf_80m01_diff got=%h exp=7f", diff); end
    checks++; if (bout !== 1'b0)    begin errors++; $display("FAIL ovf_80m01_bout got=%0b exp=0", bout); end
`ifdef SUB_OVERFLOW_EN
    checks++; if (ovf !== 1'b1)     begin errors++; $display("FAIL ovf_80m01_ovf got=%0b exp=1", ovf); end
`endif
    run_op(8'h7F, 8'hFF, lat, bn);
    checks++; if (diff !== 8'h80)   begin errors++; $display("FAIL ovf_7fmff_diff got=%h exp=80", diff); end
    checks++; if (bout !== 1'b1)    begin errors++; $display("FAIL ovf_7fmff_bout got=%0b exp=1", bout); end
`ifdef SUB_OVERFLOW_EN
    checks++; if (ovf !== 1'b1)     begin errors++; $display("FAIL ovf_7fmff_ovf got=%0b exp=1", ovf); end
`endif
  endtask

  task automatic test_ignore_start();
    int n;
    @(negedge clk);
    start = 1'b1; i_a = 8'd9; i_b = 8'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; i_a = 8'd1; i_b = 8'd1;
    checks++; if (diff !== 8'h80)   begin errors++; $display("FAIL shift_diff_stable got=%h exp=80", diff); end
    @(negedge clk);
    start = 1'b0; i_a = 8'h00; i_b = 8'h00;
    n = 3;
    while (!done && n < 40) begin @(negedge clk); n++; end
    checks++; if (n !== 9)          begin errors++; $display("FAIL ignore_latency got=%0d exp=9", n); end
    checks++; if (diff !== 8'h05)   begin errors++; $display("FAIL ignore_diff got=%h exp=05", diff); end
    @(negedge clk);
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL ignore_no_requeue got=%0b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    int n, m;
    @(negedge clk);
    start = 1'b1; i_a = 8'h10; i_b = 8'h01;
    @(negedge clk);
    n = 1;
    while (!done && n < 40) begin @(negedge clk); n++; end
    checks++; if (n !== 9)          begin errors++; $display("FAIL b2b_first_latency got=%0d exp=9", n); end
    checks++; if (diff !== 8'h0F)   begin errors++; $display("FAIL b2b_first_diff got=%h exp=0f", diff); end
    @(negedge clk);
    checks++; if (busy !== 1'b1)    begin errors++; $display("FAIL b2b_restart_busy got=%0b exp=1", busy); end
    start = 1'b0;
    m = 1;
    while (!done && m < 40) begin @(negedge clk); m++; end
    checks++; if (m !== 9)          begin errors++; $display("FAIL b2b_gap got=%0d exp=9", m); end
    checks++; if (diff !== 8'h0F)   begin errors++; $display("FAIL b2b_second_diff got=%h exp=0f", diff); end
  endtask

  task automatic test_reset_mid();
    int lat, bn;
    @(negedge clk);
    start = 1'b1; i_a = 8'h22; i_b = 8'h01;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL midrst_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL midrst_done got=%0b exp=0", done); end
    checks++; if (diff !== 8'h00)   begin errors++; $display("FAIL midrst_diff got=%h exp=00", diff); end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h22, 8'h11, lat, bn);
    checks++; if (lat !== 9)        begin errors++; $display("FAIL midrst_fresh_latency got=%0d exp=9", lat); end
    checks++; if (diff !== 8'h11)   begin errors++; $display("FAIL midrst_fresh_diff got=%h exp=11", diff); end
  endtask

  task automatic test_width1();
    int n;
    @(negedge clk);
    s1 = 1'b1; a1 = 1'b0; b1 = 1'b1;
    @(negedge clk);
    s1 = 1'b0;
    n = 1;
    while (!done1 && n < 40) begin @(negedge clk); n++; end
    checks++; if (n !== 2)          begin errors++; $display("FAIL w1_latency got=%0d exp=2", n); end
    checks++; if (diff1 !== 1'b1)   begin errors++; $display("FAIL w1_0m1_diff got=%0b exp=1", diff1); end
    checks++; if (bout1 !== 1'b1)   begin errors++; $display("FAIL w1_0m1_bout got=%0b exp=1", bout1); end
    @(negedge clk);
    s1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
    @(negedge clk);
    s1 = 1'b0;
    n = 1;
    while (!done1 && n < 40) begin @(negedge clk); n++; end
    checks++; if (diff1 !== 1'b1)   begin errors++; $display("FAIL w1_1m0_diff got=%0b exp=1", diff1); end
    checks++; if (bout1 !== 1'b0)   begin errors++; $display("FAIL w1_1m0_bout got=%0b exp=0", bout1); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; i_a = 8'h00; i_b = 8'h00;
    s1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_overflow();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_width1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
